// File: rtl/lb_mon_pkg.sv
// Shared types and constants for the lockstep load-buffer divergence monitor.
// Optional data comparison is enabled by defining LB_MON_DATA_CMP_EN.
package lb_mon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_DONE     = 3'd3,
        ST_DIVERGED = 3'd4
    } lb_mon_state_e;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_ADDR = 2'd1;
    localparam logic [1:0] CAUSE_DATA = 2'd2;
    localparam logic [1:0] CAUSE_CNT  = 2'd3;

    localparam int LB_ADDR_W = 32;
    localparam int LB_DATA_W = 32;

    // A FIFO entry is {addr, data} with data comparison, otherwise just addr.
`ifdef LB_MON_DATA_CMP_EN
    localparam int LB_ENTRY_W = LB_ADDR_W + LB_DATA_W;
`else
    localparam int LB_ENTRY_W = LB_ADDR_W;
`endif

endpackage

// File: rtl/lb_lockstep_monitor_if.sv
// Bundle of the monitor's control, observation and status signals.
// master drives arm and the lb_table observations; slave is the monitor.
interface lb_lockstep_monitor_if #(
    parameter int CNT_W = 8
);
    logic             arm;
    logic [CNT_W-1:0] window_len;
    logic             lb_valid1;
    logic             lb_valid2;
    logic [31:0]      lb_addr1;
    logic [31:0]      lb_addr2;
    logic [31:0]      lb_data1;
    logic [31:0]      lb_data2;
    logic             busy;
    logic             done;
    logic             diverge;
    logic [1:0]       diverge_cause;
    logic [CNT_W-1:0] diverge_cycle;
    logic [CNT_W-1:0] match_count;

    modport master (
        output arm, window_len,
        output lb_valid1, lb_valid2, lb_addr1, lb_addr2, lb_data1, lb_data2,
        input  busy, done, diverge, diverge_cause, diverge_cycle, match_count
    );

    modport slave (
        input  arm, window_len,
        input  lb_valid1, lb_valid2, lb_addr1, lb_addr2, lb_data1, lb_data2,
        output busy, done, diverge, diverge_cause, diverge_cycle, match_count
    );

endinterface

// File: rtl/lb_mon_fifo.sv
// Synchronous per-copy event FIFO with combinational head and flush.
// Push on a full FIFO is dropped unless a pop happens in the same cycle.
module lb_mon_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ZERO = {(AW + 1){1'b0}};
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign head      = mem_r[rd_ptr_r[AW-1:0]];

    // Read/write pointers; the extra MSB distinguishes full from empty.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Storage array; contents are don't-care outside the valid range.
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/lb_lockstep_monitor.sv
// Skew-tolerant lockstep monitor comparing lb_table event streams of two cores.
// Define LB_MON_DATA_CMP_EN to include load data in event detection and compare.
module lb_lockstep_monitor #(
    parameter int DEPTH    = 4,
    parameter int MAX_SKEW = 8,
    parameter int CNT_W    = 8
) (
    input logic                  clock,
    input logic                  reset,
    lb_lockstep_monitor_if.slave bus
);
    import lb_mon_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W - 1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] SKEW_LAST = CNT_W'(MAX_SKEW - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    lb_mon_state_e         state_r;
    lb_mon_state_e         state_nxt_s;
    logic [CNT_W-1:0]      win_len_r;
    logic [CNT_W-1:0]      win_cnt_r;
    logic [CNT_W-1:0]      win_cnt_inc_s;
    logic [CNT_W-1:0]      cyc_r;
    logic [CNT_W-1:0]      skew_r;
    logic [CNT_W-1:0]      match_r;
    logic [CNT_W-1:0]      div_cycle_r;
    logic [1:0]            cause_r;
    logic [1:0]            cause_s;
    logic                  busy_r;
    logic                  done_r;
    logic                  diverge_r;
    logic                  prev_valid1_r;
    logic                  prev_valid2_r;
    logic [LB_ADDR_W-1:0]  prev_addr1_r;
    logic [LB_ADDR_W-1:0]  prev_addr2_r;
    logic                  arm_ok_s;
    logic                  active_s;
    logic                  ev1_s;
    logic                  ev2_s;
    logic                  cmp_s;
    logic                  addr_ne_s;
    logic                  data_ne_s;
    logic                  one_ne_s;
    logic                  skew_hit_s;
    logic                  ovf_s;
    logic                  drain_miss_s;
    logic [LB_ENTRY_W-1:0] entry1_s;
    logic [LB_ENTRY_W-1:0] entry2_s;
    logic [LB_ENTRY_W-1:0] head1_s;
    logic [LB_ENTRY_W-1:0] head2_s;
    logic                  full1_s;
    logic                  full2_s;
    logic                  empty1_s;
    logic                  empty2_s;

    assign arm_ok_s = bus.arm && ((state_r == ST_IDLE) || (state_r == ST_DONE) ||
                                  (state_r == ST_DIVERGED));
    assign active_s = (state_r == ST_RUN) || (state_r == ST_DRAIN);
    assign win_cnt_inc_s = win_cnt_r + CNT_ONE;

`ifdef LB_MON_DATA_CMP_EN
    logic [LB_DATA_W-1:0] prev_data1_r;
    logic [LB_DATA_W-1:0] prev_data2_r;

    assign entry1_s  = {bus.lb_addr1, bus.lb_data1};
    assign entry2_s  = {bus.lb_addr2, bus.lb_data2};
    assign data_ne_s = (head1_s[LB_DATA_W-1:0] != head2_s[LB_DATA_W-1:0]);

    // Per-copy event detection: new valid, new address or new data.
    always_comb begin
        ev1_s = 1'b0;
        ev2_s = 1'b0;
        if (state_r == ST_RUN) begin
            ev1_s = bus.lb_valid1 && (!prev_valid1_r || (bus.lb_addr1 != prev_addr1_r) ||
                                      (bus.lb_data1 != prev_data1_r));
            ev2_s = bus.lb_valid2 && (!prev_valid2_r || (bus.lb_addr2 != prev_addr2_r) ||
                                      (bus.lb_data2 != prev_data2_r));
        end else begin
            ev1_s = 1'b0;
            ev2_s = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || arm_ok_s) begin
            prev_data1_r <= {LB_DATA_W{1'b0}};
            prev_data2_r <= {LB_DATA_W{1'b0}};
        end else if (state_r == ST_RUN) begin
            prev_data1_r <= bus.lb_data1;
            prev_data2_r <= bus.lb_data2;
        end
    end
`else
    logic unused_data_s;

    assign unused_data_s = ^{bus.lb_data1, bus.lb_data2};
    assign entry1_s      = bus.lb_addr1;
    assign entry2_s      = bus.lb_addr2;
    assign data_ne_s     = 1'b0;

    // Per-copy event detection: new valid or new address.
    always_comb begin
        ev1_s = 1'b0;
        ev2_s = 1'b0;
        if (state_r == ST_RUN) begin
            ev1_s = bus.lb_valid1 && (!prev_valid1_r || (bus.lb_addr1 != prev_addr1_r));
            ev2_s = bus.lb_valid2 && (!prev_valid2_r || (bus.lb_addr2 != prev_addr2_r));
        end else begin
            ev1_s = 1'b0;
            ev2_s = 1'b0;
        end
    end
`endif

    lb_mon_fifo #(.WIDTH(LB_ENTRY_W), .DEPTH(DEPTH)) u_fifo1 (
        .clock (clock),
        .reset (reset),
        .flush (arm_ok_s),
        .push  (ev1_s),
        .pop   (cmp_s),
        .din   (entry1_s),
        .head  (head1_s),
        .full  (full1_s),
        .empty (empty1_s)
    );

    lb_mon_fifo #(.WIDTH(LB_ENTRY_W), .DEPTH(DEPTH)) u_fifo2 (
        .clock (clock),
        .reset (reset),
        .flush (arm_ok_s),
        .push  (ev2_s),
        .pop   (cmp_s),
        .din   (entry2_s),
        .head  (head2_s),
        .full  (full2_s),
        .empty (empty2_s)
    );

    assign cmp_s        = active_s && !empty1_s && !empty2_s;
    assign addr_ne_s    = (head1_s[LB_ENTRY_W-1 -: LB_ADDR_W] != head2_s[LB_ENTRY_W-1 -: LB_ADDR_W]);
    assign one_ne_s     = empty1_s ^ empty2_s;
    assign skew_hit_s   = active_s && one_ne_s && (skew_r == SKEW_LAST);
    assign ovf_s        = (ev1_s && full1_s && !cmp_s) || (ev2_s && full2_s && !cmp_s);
    assign drain_miss_s = (state_r == ST_DRAIN) && one_ne_s;

    // Cause priority: the lowest non-zero code wins.
    always_comb begin
        cause_s = CAUSE_NONE;
        if (cmp_s && addr_ne_s) begin
            cause_s = CAUSE_ADDR;
        end else if (cmp_s && data_ne_s) begin
            cause_s = CAUSE_DATA;
        end else if (ovf_s || skew_hit_s || drain_miss_s) begin
            cause_s = CAUSE_CNT;
        end else begin
            cause_s = CAUSE_NONE;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_DIVERGED: begin
                if (bus.arm) begin
                    state_nxt_s = (bus.window_len == CNT_ZERO) ? ST_DRAIN : ST_RUN;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_RUN: begin
                if (cause_s != CAUSE_NONE) begin
                    state_nxt_s = ST_DIVERGED;
                end else if (win_cnt_inc_s == win_len_r) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (cause_s != CAUSE_NONE) begin
                    state_nxt_s = ST_DIVERGED;
                end else if (empty1_s && empty2_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and registered status flags decoded from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            diverge_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            busy_r    <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DRAIN);
            done_r    <= (state_nxt_s == ST_DONE);
            diverge_r <= (state_nxt_s == ST_DIVERGED);
        end
    end

    // Window bookkeeping, counters, prev-sample registers and divergence stamp.
    always_ff @(posedge clock) begin
        if (reset || arm_ok_s) begin
            win_len_r     <= reset ? CNT_ZERO : bus.window_len;
            win_cnt_r     <= CNT_ZERO;
            cyc_r         <= CNT_ZERO;
            skew_r        <= CNT_ZERO;
            match_r       <= CNT_ZERO;
            cause_r       <= CAUSE_NONE;
            div_cycle_r   <= CNT_ZERO;
            prev_valid1_r <= 1'b0;
            prev_valid2_r <= 1'b0;
            prev_addr1_r  <= {LB_ADDR_W{1'b0}};
            prev_addr2_r  <= {LB_ADDR_W{1'b0}};
        end else if (active_s) begin
            cyc_r  <= sat_inc(cyc_r);
            skew_r <= one_ne_s ? sat_inc(skew_r) : CNT_ZERO;
            if (state_r == ST_RUN) begin
                win_cnt_r     <= win_cnt_inc_s;
                prev_valid1_r <= bus.lb_valid1;
                prev_valid2_r <= bus.lb_valid2;
                prev_addr1_r  <= bus.lb_addr1;
                prev_addr2_r  <= bus.lb_addr2;
            end
            if (cmp_s && !addr_ne_s && !data_ne_s) begin
                match_r <= sat_inc(match_r);
            end
            if (cause_s != CAUSE_NONE) begin
                cause_r     <= cause_s;
                div_cycle_r <= cyc_r;
            end
        end
    end

    assign bus.busy          = busy_r;
    assign bus.done          = done_r;
    assign bus.diverge       = diverge_r;
    assign bus.diverge_cause = cause_r;
    assign bus.diverge_cycle = div_cycle_r;
    assign bus.match_count   = match_r;

endmodule

// File: tb/tb_lb_lockstep_monitor.sv
// Directed self-checking bench for lb_lockstep_monitor (DEPTH=4, MAX_SKEW=8).
// Cycle numbers below count from the first RUN cycle after an accepted arm.
module tb_lb_lockstep_monitor;

    logic clock = 1'b0;
    logic reset;
    int   err_cnt = 0;
    int   chk_cnt = 0;

    always #5 clock = ~clock;

    lb_lockstep_monitor_if #(.CNT_W(8)) bus ();

    lb_lockstep_monitor #(.DEPTH(4), .MAX_SKEW(8), .CNT_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v1, input logic [31:0] a1, input logic [31:0] d1,
                         input logic v2, input logic [31:0] a2, input logic [31:0] d2);
        bus.lb_valid1 = v1;
        bus.lb_addr1  = a1;
        bus.lb_data1  = d1;
        bus.lb_valid2 = v2;
        bus.lb_addr2  = a2;
        bus.lb_data2  = d2;
    endtask

    // Leaves the bench in RUN cycle 0 (or the first DRAIN cycle for len 0).
    task automatic do_arm(input logic [7:0] wl);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        bus.arm        = 1'b1;
        bus.window_len = wl;
        tick();
        bus.arm = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget);
        int n;
        n = 0;
        while (!(bus.done || bus.diverge) && (n < budget)) begin
            tick();
            n++;
        end
        check({tag, "_finished"}, {31'd0, bus.done | bus.diverge}, 32'd1);
    endtask

    task automatic check_status(input string tag, input logic dn, input logic dv,
                                input logic [1:0] cs, input logic [7:0] cy);
        check({tag, "_done"}, {31'd0, bus.done}, {31'd0, dn});
        check({tag, "_diverge"}, {31'd0, bus.diverge}, {31'd0, dv});
        check({tag, "_cause"}, {30'd0, bus.diverge_cause}, {30'd0, cs});
        check({tag, "_cycle"}, {24'd0, bus.diverge_cycle}, {24'd0, cy});
    endtask

    initial begin
        reset          = 1'b1;
        bus.arm        = 1'b0;
        bus.window_len = 8'd0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_match", {24'd0, bus.match_count}, 32'd0);
        check_status("rst", 1'b0, 1'b0, 2'd0, 8'd0);

        // Identical streams: 0x64 from cycle 3, 0x68 from cycle 6; arm at cycle 10 ignored.
        do_arm(8'd20);
        check("t1_busy_after_arm", {31'd0, bus.busy}, 32'd1);
        for (int c = 0; c < 20; c++) begin
            drive(c >= 3, (c >= 6) ? 32'h68 : 32'h64, 32'h0,
                  c >= 3, (c >= 6) ? 32'h68 : 32'h64, 32'h0);
            bus.arm        = (c == 10);
            bus.window_len = 8'd3;
            tick();
            bus.arm = 1'b0;
            if (c == 4) check("t1_match_mid", {24'd0, bus.match_count}, 32'd1);
        end
        check("t1_busy_drain", {31'd0, bus.busy}, 32'd1);
        tick();
        check_status("t1", 1'b1, 1'b0, 2'd0, 8'd0);
        check("t1_match", {24'd0, bus.match_count}, 32'd2);
        check("t1_busy_done", {31'd0, bus.busy}, 32'd0);
        tick();
        tick();
        check("t1_done_sticky", {31'd0, bus.done}, 32'd1);

        // Address mismatch at cycle 3, compared in cycle 4, visible in cycle 5.
        do_arm(8'd20);
        for (int c = 0; c < 5; c++) begin
            drive(c >= 3, 32'h64, 32'h0, c >= 3, 32'h80, 32'h0);
            tick();
        end
        check_status("t2", 1'b0, 1'b1, 2'd1, 8'd4);
        check("t2_busy", {31'd0, bus.busy}, 32'd0);
        tick();
        tick();
        check("t2_sticky", {31'd0, bus.diverge}, 32'd1);

        // Skew of 3 cycles: copy1 at cycle 2, copy2 at cycle 5.
        do_arm(8'd12);
        check_status("t3_rearm", 1'b0, 1'b0, 2'd0, 8'd0);
        for (int c = 0; c < 12; c++) begin
            drive(c >= 2, 32'h64, 32'h0, c >= 5, 32'h64, 32'h0);
            tick();
        end
        wait_end("t3", 5);
        check_status("t3", 1'b1, 1'b0, 2'd0, 8'd0);
        check("t3_match", {24'd0, bus.match_count}, 32'd1);

        // Skew of 9 cycles: one-sided from cycle 3, eighth such cycle is 10.
        do_arm(8'd20);
        for (int c = 0; c < 11; c++) begin
            drive(c >= 2, 32'h64, 32'h0, c >= 11, 32'h64, 32'h0);
            tick();
        end
        check_status("t4", 1'b0, 1'b1, 2'd3, 8'd10);

        // Missing event: window 5, copy1 event at cycle 1, caught at DRAIN entry (cycle 5).
        do_arm(8'd5);
        for (int c = 0; c < 5; c++) begin
            drive(c >= 1, 32'h64, 32'h0, 1'b0, 32'h0, 32'h0);
            tick();
        end
        check("t5_no_early", {31'd0, bus.diverge}, 32'd0);
        tick();
        check_status("t5", 1'b0, 1'b1, 2'd3, 8'd5);

        // Overflow: copy1 events in cycles 1..5, fifth push into a full FIFO at cycle 5.
        do_arm(8'd20);
        for (int c = 0; c < 6; c++) begin
            drive(c >= 1, 32'h100 + 32'(4 * c), 32'h0, 1'b0, 32'h0, 32'h0);
            tick();
            if (c == 4) check("t6_full_ok", {31'd0, bus.diverge}, 32'd0);
        end
        check_status("t6", 1'b0, 1'b1, 2'd3, 8'd5);

        // Same address, different data from cycle 2; compared in cycle 3.
        do_arm(8'd8);
        for (int c = 0; c < 4; c++) begin
            drive(c >= 2, 32'h64, 32'h1, c >= 2, 32'h64, 32'h2);
            tick();
        end
`ifdef LB_MON_DATA_CMP_EN
        check_status("t7", 1'b0, 1'b1, 2'd2, 8'd3);
`else
        check("t7_match_mid", {24'd0, bus.match_count}, 32'd1);
        wait_end("t7", 10);
        check_status("t7", 1'b1, 1'b0, 2'd0, 8'd0);
        check("t7_match", {24'd0, bus.match_count}, 32'd1);
`endif

        // Zero-length window goes straight to DRAIN, then DONE.
        do_arm(8'd0);
        check("t8_busy", {31'd0, bus.busy}, 32'd1);
        tick();
        check_status("t8", 1'b1, 1'b0, 2'd0, 8'd0);
        check("t8_match", {24'd0, bus.match_count}, 32'd0);

        // Reset mid-RUN after one match.
        do_arm(8'd20);
        for (int c = 0; c < 3; c++) begin
            drive(c >= 1, 32'h64, 32'h0, c >= 1, 32'h64, 32'h0);
            tick();
        end
        check("t9_match_pre", {24'd0, bus.match_count}, 32'd1);
        check("t9_busy_pre", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t9_busy", {31'd0, bus.busy}, 32'd0);
        check("t9_match", {24'd0, bus.match_count}, 32'd0);
        check_status("t9", 1'b0, 1'b0, 2'd0, 8'd0);
        tick();
        tick();
        check("t9_stay_idle", {31'd0, bus.busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
